fft16_digit_reverse_buf: RTL and testbench



---
 rtl/fft16_pkg.sv | 23 ++
 rtl/fft16_bank_ram.sv | 27 ++
 rtl/fft16_digit_reverse_buf.sv | 177 +++++++++++++++++
 tb/tb_fft16_digit_reverse_buf.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared types and helpers for the 16-point radix-4 FFT datapath.
// Holds the frame constants, the complex sample type, the read FSM state and the base-4 digit reversal.
package fft16_pkg;

    localparam int DATA_W = 32;
    localparam int N      = 16;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Swapping the two base-4 digits of a 4-bit index.
    function automatic logic [3:0] digit_rev4(input logic [3:0] idx);
        return {idx[1:0], idx[3:2]};
    endfunction

endpackage

// File: rtl/fft16_bank_ram.sv
// One ping-pong bank: 16-entry register file, single write port, asynchronous read port.
// Contents are not reset; the owning buffer's full flags decide what is valid.
module fft16_bank_ram
    import fft16_pkg::*;
#(
    parameter int W     = 2 * DATA_W,
    parameter int DEPTH = N
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft16_digit_reverse_buf.sv
// Ping-pong reorder buffer: natural-order samples in, base-4 digit-reversed 16-sample frames out.
// Optional FFT16_SYNC_CHECK_EN adds in_last framing check with sticky sync_err.
module fft16_digit_reverse_buf #(
    parameter int DATA_W = 32,
    parameter int N      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_re,
    input  logic [DATA_W-1:0]     in_im,
`ifdef FFT16_SYNC_CHECK_EN
    input  logic                  in_last,
    output logic                  sync_err,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_re,
    output logic [DATA_W-1:0]     out_im,
    output logic [3:0]            out_idx,
    output logic                  out_last,
    output fft16_pkg::rd_state_e  dbg_rd_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready; valid and its
    // payload never depend combinationally on ready, and a presented output holds until taken.

    fft16_pkg::rd_state_e state_q, state_d;

    logic [1:0]        full_q, full_d;
    logic              wb_q, wb_d, rb_q, rb_d;
    logic [3:0]        wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    fft16_pkg::cplx_t  out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;

    logic              wr_fire, wr_last;
    logic              rd_active, rd_load, rd_last;
    logic [3:0]        rd_addr;
    logic [1:0]        bank_we;
    fft16_pkg::cplx_t  wr_data, rd_data, rd_data_0, rd_data_1;

    assign in_ready = !full_q[wb_q];
    assign wr_fire  = in_valid && in_ready;
    assign wr_last  = wr_fire && (wcnt_q == 4'(N - 1));
    assign wr_data  = '{re: in_re, im: in_im};
    assign bank_we  = {wr_fire && wb_q, wr_fire && !wb_q};

    assign rd_addr   = fft16_pkg::digit_rev4(rcnt_q);
    assign rd_data   = rb_q ? rd_data_1 : rd_data_0;
    // IDLE may load straight away so x[0] appears one edge after the frame completes.
    assign rd_active = (state_q == fft16_pkg::RD_STREAM) || full_q[rb_q];
    assign rd_load   = rd_active && (!out_valid_q || out_ready);
    assign rd_last   = rd_load && (rcnt_q == 4'(N - 1));

    fft16_bank_ram #(.W($bits(fft16_pkg::cplx_t)), .DEPTH(N)) u_bank_0 (
        .clk   (clk),
        .we    (bank_we[0]),
        .waddr (wcnt_q),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data_0)
    );

    fft16_bank_ram #(.W($bits(fft16_pkg::cplx_t)), .DEPTH(N)) u_bank_1 (
        .clk   (clk),
        .we    (bank_we[1]),
        .waddr (wcnt_q),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data_1)
    );

    always_comb begin
        wcnt_d = wcnt_q;
        wb_d   = wb_q ^ wr_last;
        rcnt_d = rd_load ? rcnt_q + 4'd1 : rcnt_q;
        rb_d   = rb_q ^ rd_last;
        if (wr_fire) begin
            wcnt_d = wcnt_q + 4'd1;
`ifdef FFT16_SYNC_CHECK_EN
            if (in_last && !wr_last) begin
                wcnt_d = '0;
            end
`endif
        end
        for (int b = 0; b < 2; b++) begin
            full_d[b] = full_q[b];
            if (wr_last && (wb_q == 1'(b))) full_d[b] = 1'b1;
            if (rd_last && (rb_q == 1'(b))) full_d[b] = 1'b0;
        end
    end

`ifdef FFT16_SYNC_CHECK_EN
    logic sync_err_q, sync_err_d;

    assign sync_err_d = sync_err_q || (wr_fire && (in_last != (wcnt_q == 4'(N - 1))));
    assign sync_err   = sync_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_err_q <= 1'b0;
        else        sync_err_q <= sync_err_d;
    end
`endif

    // Read FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= fft16_pkg::RD_IDLE;
        else        state_q <= state_d;
    end

    // Read FSM: next state; back-to-back frames stay in STREAM without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            fft16_pkg::RD_IDLE: begin
                if (full_q[rb_q]) state_d = fft16_pkg::RD_STREAM;
            end
            fft16_pkg::RD_STREAM: begin
                if (rd_last) begin
                    state_d = full_q[!rb_q] ? fft16_pkg::RD_STREAM : fft16_pkg::RD_IDLE;
                end
            end
            default: state_d = fft16_pkg::RD_IDLE;
        endcase
    end

    // Read FSM: output register next values.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        if (rd_load) begin
            out_d       = rd_data;
            out_valid_d = 1'b1;
            out_idx_d   = rd_addr;
            out_last_d  = (rcnt_q == 4'(N - 1));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_re       = out_q.re;
    assign out_im       = out_q.im;
    assign out_idx      = out_idx_q;
    assign out_last     = out_last_q;
    assign dbg_rd_state = state_q;

endmodule

// File: tb/tb_fft16_digit_reverse_buf.sv
// Scoreboard bench for fft16_digit_reverse_buf: directed frames, expected words queued at issue time.
// Build with FFT16_SYNC_CHECK_EN to also exercise the in_last framing check.
module tb_fft16_digit_reverse_buf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_re, in_im;
    logic        in_last;
    logic        sync_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_re, out_im;
    logic [3:0]  out_idx;
    logic        out_last;
    fft16_pkg::rd_state_e dbg_rd_state;

    int checks = 0;
    int errors = 0;
    int wait_cnt = 0;
    bit stall_run = 0;

    // Hand-written base-4 digit-reversed order of one frame.
    int rev_tab[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    logic [68:0] exp_q[$];

    fft16_digit_reverse_buf dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_re        (in_re),
        .in_im        (in_im),
`ifdef FFT16_SYNC_CHECK_EN
        .in_last      (in_last),
        .sync_err     (sync_err),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_re       (out_re),
        .out_im       (out_im),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .dbg_rd_state (dbg_rd_state)
    );

`ifndef FFT16_SYNC_CHECK_EN
    assign sync_err = 1'b0;
`endif

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Helpers
    function automatic logic [68:0] exp_word(input int base, input int j);
        logic [31:0] re;
        re = 32'(base + rev_tab[j]);
        return {re, -re, 4'(rev_tab[j]), (j == 15)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Driver tasks
    task automatic send_sample(input logic [31:0] re, input logic [31:0] im, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        if (n > 0) wait_cnt++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit push);
        if (push) begin
            for (int j = 0; j < 16; j++) exp_q.push_back(exp_word(base, j));
        end
        for (int k = 0; k < 16; k++) begin
            send_sample(32'(base + k), -32'(base + k), k == 15);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d outputs still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops on every accepted output, checks hold during stalls
    logic [69:0] held;
    bit          held_v = 0;

    always @(negedge clk) begin
        logic [68:0] act;
        logic [68:0] exp;
        act = {out_re, out_im, out_idx, out_last};
        if (!rst_n) begin
            held_v = 0;
        end else begin
            if (held_v) begin
                checks++;
                if ({act, out_valid} !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got %h expected %h", {act, out_valid}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got %h expected no output", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL out_word: got re=%0d im=%0d idx=%0d last=%0b expected re=%0d im=%0d idx=%0d last=%0b",
                                 $signed(act[68:37]), $signed(act[36:5]), act[4:1], act[0],
                                 $signed(exp[68:37]), $signed(exp[36:5]), exp[4:1], exp[0]);
                    end
                end
            end
            held_v = out_valid && !out_ready;
            held   = {act, out_valid};
        end
    end

    // Stimulus
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_re", out_re, 32'd0);
        check("rst_out_im", out_im, 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame and first-output latency
        send_frame(0, 1);
        check("lat_before", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_first", 32'(out_valid), 32'd1);
        drain("frame0");

        // Three back-to-back frames: no output bubbles, no input backpressure
        wait_cnt = 0;
        fork
            begin
                send_frame(1000, 1);
                send_frame(2000, 1);
                send_frame(3000, 1);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 48; i++) begin
                    if (i > 0) @(negedge clk);
                    check("no_bubble", 32'(out_valid), 32'd1);
                end
            end
        join
        check("b2b_in_ready", 32'(wait_cnt), 32'd0);
        drain("b2b");

        // Output blocked while two frames are offered
        out_ready = 1'b0;
        wait_cnt  = 0;
        send_frame(4000, 1);
        send_frame(5000, 1);
        check("fill_no_wait", 32'(wait_cnt), 32'd0);
        repeat (4) @(negedge clk);
        check("both_full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("in_ready_before_free", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_free", 32'(in_ready), 32'd1);
        drain("blocked");

        // Ten frames under random output stalls
        stall_run = 1;
        fork
            begin
                for (int f = 0; f < 10; f++) send_frame(10000 + 100 * f, 1);
                stall_run = 0;
            end
            begin
                while (stall_run) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain("stall");

        // Reset mid-frame discards the partial frame
        for (int k = 0; k < 7; k++) send_sample(32'(50 + k), 32'(60 + k), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_re", out_re, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(100, 1);
        drain("after_rst");

`ifdef FFT16_SYNC_CHECK_EN
        // Early in_last resyncs the write counter and sets the sticky error
        for (int k = 0; k < 10; k++) send_sample(32'(70 + k), 32'(80 + k), k == 9);
        check("sync_err_set", 32'(sync_err), 32'd1);
        send_frame(200, 1);
        drain("sync");
        check("sync_err_sticky", 32'(sync_err), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
